quad_encoder_frontend: RTL and testbench
========================================

// Module: quad_encoder_frontend
// PURPOSE
// Upstream stage of the RPM measurement block. Takes raw quadrature channels A/B
// from the motor encoder and produces clean count events for the RPM stage:
// - synchronises both channels and glitch-filters them
// - decodes direction and drives a wrapping position counter
// - emits a square-wave "ticks" level, which feeds the RPM block's ticks input directly.
// PARAMETERS
// FILTER_LEN   4    consecutive clocks a synchronised level must hold before acceptance (>=1)
// POS_W        16   width of position counter
// DECODE_MODE  4    4: count every legal edge; 2: count A edges only; 1: count A rising only
// PORTS
// clk         in   1      system clock (25 MHz nominal)
// rst_n       in   1      asynchronous active-low reset
// enc_a       in   1      raw encoder channel A (asynchronous)
// enc_b       in   1      raw encoder channel B (asynchronous)
// pos_clr     in   1      synchronous clear of position
// err_clr     in   1      synchronous clear of err
// ticks       out  1      toggles on every counted event (to RPM stage)
// tick_pulse  out  1      1-cycle strobe per counted event
// dir         out  1      1 = forward (A leads B), 0 = reverse; direction of last counted event
// position    out  POS_W  signed two's-complement position, wraps modulo 2^POS_W
// err         out  1      sticky: illegal transition seen
// BEHAVIOUR
// - Reset (rst_n=0, async): all outputs 0, both sync flops 0, filtered A/B = 00, prev state 00, filter counters 0.
// - Sync: 2-flop synchroniser per channel; nothing downstream uses raw enc_a/enc_b.
// - Filter (per channel):
//   - If sync2 != filtered level: counter increments; on the clock where it reaches FILTER_LEN, the filtered level takes sync2 and the counter returns to 0.
//   - If sync2 == filtered level: counter clears to 0. Any bounce restarts the count.
// - Decode, evaluated each clock on filtered {A,B} vs prev {A,B}:
//   - Forward sequence 00->10->11->01->00; reverse is the opposite order.
//   - Legal step: counted per DECODE_MODE. Counted => tick_pulse=1 next cycle, ticks toggles, dir set, position +1 (fwd) / -1 (rev).
//   - Uncounted legal step (mode 1/2 on a B edge, mode 1 on A falling) => no outputs change, prev updates.
//   - Both bits changed together => illegal: err<=1, no count, dir/position unchanged, prev updates.
//   - No change => nothing.
// - Latency: new level first sampled at edge 1 -> sync2 at edge 2 -> filtered at edge FILTER_LEN+2 -> tick_pulse/ticks/position/dir updated at edge FILTER_LEN+3 (7 for default). tick_pulse is high exactly one cycle.
// - Throughput: at most one counted event per clock. Min channel dwell for guaranteed count is FILTER_LEN+1 clocks.
// - Wrap: position 2^(POS_W-1)-1 +1 -> -2^(POS_W-1), and the reverse; no saturation, no flag.
// - Precedence:
//   - pos_clr wins over a simultaneous count: position=0, but tick_pulse/ticks/dir still update.
//   - A simultaneous illegal event wins over err_clr: err stays 1.
// - Reset mid-operation: immediate async clear. Channels resting at 11 after reset produce filtered 00->11 = one illegal event; this is acceptable and sets err.
// TESTING
// 1 Fwd sweep 00->10->11->01->00, 200 clk per state, mode 4 -> 4 tick_pulses, position=4, dir=1, ticks toggles 4x ending 0.
// 2 Reverse 4 steps from reset, mode 4 -> position=-4 (0xFFFC), dir=0; each pulse at edge 7 after input change.
// 3 Glitch: A high for 3 clk then low (FILTER_LEN=4) -> no pulse, position 0; A high 4 clk -> pulse.
// 4 A and B flip together 00->11 -> err=1, position unchanged; err_clr -> err=0; err_clr coincident with a second illegal event -> err stays 1.
// 5 Mode 1, full fwd cycle x3 -> 3 pulses, position=3. Mode 2, same stimulus -> position=6.
// 6 POS_W=4 at position 7, one fwd step -> -8. pos_clr coincident with a step -> position 0, tick_pulse=1. rst_n low mid-sequence -> all outputs 0 immediately.

Source files
------------

// File: rtl/quad_encoder_frontend.sv
// quad_encoder_frontend
// Front end for the RPM measurement block. Raw quadrature channels A/B are
// synchronised, glitch-filtered and decoded into count events.
//
// Parameters:
//   FILTER_LEN   clocks a synchronised level must persist before acceptance (>=1)
//   POS_W        position counter width
//   DECODE_MODE  4: every legal edge, 2: A edges only, 1: A rising edges only
//
// Ports:
//   clk, rst_n         system clock, asynchronous active-low reset
//   enc_a, enc_b       raw asynchronous encoder channels
//   pos_clr, err_clr   synchronous clears of position / err
//   ticks              toggles once per counted event (feeds the RPM stage)
//   tick_pulse         one-cycle strobe per counted event
//   dir                direction of last counted event (1 = A leads B)
//   position           wrapping two's-complement position
//   err                sticky flag, set when both filtered channels change together
module quad_encoder_frontend #(
    parameter int unsigned FILTER_LEN  = 4,
    parameter int unsigned POS_W       = 16,
    parameter int unsigned DECODE_MODE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enc_a,
    input  logic             enc_b,
    input  logic             pos_clr,
    input  logic             err_clr,
    output logic             ticks,
    output logic             tick_pulse,
    output logic             dir,
    output logic [POS_W-1:0] position,
    output logic             err
);

    // The counter only ever holds 0..FILTER_LEN-1: the clock on which it would
    // reach FILTER_LEN is the clock the new level is accepted and it returns to 0.
    localparam int unsigned      CNT_W    = (FILTER_LEN < 2) ? 1 : $clog2(FILTER_LEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);
    localparam logic [POS_W-1:0] POS_ONE  = POS_W'(1);

    // Bit 1 = channel A, bit 0 = channel B throughout.
    logic [1:0]       sync1_q;
    logic [1:0]       sync2_q;
    logic [1:0]       filt_q;
    logic [1:0]       filt_d;
    logic [1:0]       prev_q;
    logic [CNT_W-1:0] cnt_q [2];
    logic [CNT_W-1:0] cnt_d [2];

    logic             ticks_q, ticks_d;
    logic             pulse_q, pulse_d;
    logic             dir_q, dir_d;
    logic [POS_W-1:0] pos_q, pos_d;
    logic             err_q, err_d;

    logic [1:0]       chg;
    logic             legal;
    logic             illegal;
    logic             fwd;
    logic             counted;

    // Glitch filter: a mismatch must persist for FILTER_LEN consecutive clocks.
    always_comb begin
        filt_d = filt_q;
        for (int unsigned i = 0; i < 2; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != filt_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    filt_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // Decode filtered state against the previous filtered state.
    always_comb begin
        chg     = filt_q ^ prev_q;
        legal   = (chg == 2'b01) || (chg == 2'b10);
        illegal = (chg == 2'b11);
        // For a single-bit step of the Gray sequence 00->10->11->01, the step is
        // forward exactly when the new A differs from the old B.
        fwd     = filt_q[1] ^ prev_q[0];

        if (DECODE_MODE == 1) begin
            counted = legal && chg[1] && filt_q[1];
        end else if (DECODE_MODE == 2) begin
            counted = legal && chg[1];
        end else begin
            counted = legal;
        end

        pulse_d = counted;
        ticks_d = ticks_q ^ counted;
        dir_d   = counted ? fwd : dir_q;

        pos_d = pos_q;
        if (pos_clr) begin
            pos_d = '0;
        end else if (counted) begin
            pos_d = fwd ? (pos_q + POS_ONE) : (pos_q - POS_ONE);
        end

        err_d = err_q;
        if (illegal) begin
            err_d = 1'b1;
        end else if (err_clr) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            filt_q  <= '0;
            prev_q  <= '0;
            for (int unsigned i = 0; i < 2; i++) begin
                cnt_q[i] <= '0;
            end
            ticks_q <= 1'b0;
            pulse_q <= 1'b0;
            dir_q   <= 1'b0;
            pos_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            sync1_q <= {enc_a, enc_b};
            sync2_q <= sync1_q;
            filt_q  <= filt_d;
            prev_q  <= filt_q;
            for (int unsigned i = 0; i < 2; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            ticks_q <= ticks_d;
            pulse_q <= pulse_d;
            dir_q   <= dir_d;
            pos_q   <= pos_d;
            err_q   <= err_d;
        end
    end

    assign ticks      = ticks_q;
    assign tick_pulse = pulse_q;
    assign dir        = dir_q;
    assign position   = pos_q;
    assign err        = err_q;

endmodule

// File: tb/tb_quad_encoder_frontend.sv
// Bench for quad_encoder_frontend: four instances share the encoder inputs
// (mode 4, mode 2, mode 1 at 16 bits, and mode 4 at 4 bits) and are compared
// against a Gray-index reference model of the quadrature rules.
module tb_quad_encoder_frontend;

    localparam int FL  = 4;
    localparam int LAT = FL + 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enc_a, enc_b, pos_clr, err_clr;
    logic [3:0]  ticks_v, pulse_v, dir_v, err_v;
    logic [15:0] pos_m4, pos_m2, pos_m1;
    logic [3:0]  pos_w4;

    int   mode_of [4] = '{4, 2, 1, 4};
    int   m_pos [4];
    bit   m_ticks [4];
    bit   m_dir [4];
    bit   m_err [4];
    logic [1:0] m_ab;
    int   exp_cnt [4];
    int   pulses [4];
    int   first_edge [4];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    quad_encoder_frontend #(.FILTER_LEN(FL), .POS_W(16), .DECODE_MODE(4)) u_m4 (
        .clk(clk), .rst_n(rst_n), .enc_a(enc_a), .enc_b(enc_b), .pos_clr(pos_clr), .err_clr(err_clr),
        .ticks(ticks_v[0]), .tick_pulse(pulse_v[0]), .dir(dir_v[0]), .position(pos_m4), .err(err_v[0]));
    quad_encoder_frontend #(.FILTER_LEN(FL), .POS_W(16), .DECODE_MODE(2)) u_m2 (
        .clk(clk), .rst_n(rst_n), .enc_a(enc_a), .enc_b(enc_b), .pos_clr(pos_clr), .err_clr(err_clr),
        .ticks(ticks_v[1]), .tick_pulse(pulse_v[1]), .dir(dir_v[1]), .position(pos_m2), .err(err_v[1]));
    quad_encoder_frontend #(.FILTER_LEN(FL), .POS_W(16), .DECODE_MODE(1)) u_m1 (
        .clk(clk), .rst_n(rst_n), .enc_a(enc_a), .enc_b(enc_b), .pos_clr(pos_clr), .err_clr(err_clr),
        .ticks(ticks_v[2]), .tick_pulse(pulse_v[2]), .dir(dir_v[2]), .position(pos_m1), .err(err_v[2]));
    quad_encoder_frontend #(.FILTER_LEN(FL), .POS_W(4), .DECODE_MODE(4)) u_w4 (
        .clk(clk), .rst_n(rst_n), .enc_a(enc_a), .enc_b(enc_b), .pos_clr(pos_clr), .err_clr(err_clr),
        .ticks(ticks_v[3]), .tick_pulse(pulse_v[3]), .dir(dir_v[3]), .position(pos_w4), .err(err_v[3]));

    // ---------------- reference model ----------------
    // Position of an {A,B} state along the forward cycle 00->10->11->01.
    function automatic int gidx(input logic [1:0] ab);
        case (ab)
            2'b00:   return 0;
            2'b10:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    function automatic logic [1:0] from_idx(input int i);
        case (i % 4)
            0:       return 2'b00;
            1:       return 2'b10;
            2:       return 2'b11;
            default: return 2'b01;
        endcase
    endfunction

    // 0 = no move, 1 = forward, 3 = reverse, 2 = jumped two places (illegal)
    function automatic int step_of(input logic [1:0] p, input logic [1:0] n);
        return (gidx(n) - gidx(p) + 4) % 4;
    endfunction

    function automatic bit counts(input int mode, input logic [1:0] p, input logic [1:0] n);
        int st;
        st = step_of(p, n);
        if (st != 1 && st != 3) return 1'b0;
        if (mode == 4) return 1'b1;
        if (mode == 2) return p[1] != n[1];
        return (p[1] == 1'b0) && (n[1] == 1'b1);
    endfunction

    function automatic int act_pos(input int k);
        case (k)
            0:       return int'(pos_m4);
            1:       return int'(pos_m2);
            2:       return int'(pos_m1);
            default: return int'(pos_w4);
        endcase
    endfunction

    function automatic int exp_pos(input int k);
        return (k == 3) ? (m_pos[k] & 'hF) : (m_pos[k] & 'hFFFF);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            m_pos[k] = 0; m_ticks[k] = 0; m_dir[k] = 0; m_err[k] = 0;
        end
        m_ab = 2'b00;
    endtask

    task automatic model_apply(input logic [1:0] ab, input bit pclr, input bit eclr);
        for (int k = 0; k < 4; k++) begin
            int st;
            bit c;
            st = step_of(m_ab, ab);
            c  = counts(mode_of[k], m_ab, ab);
            exp_cnt[k] += int'(c);
            if (c) begin
                m_ticks[k] = ~m_ticks[k];
                m_dir[k]   = (st == 1);
            end
            if (pclr)   m_pos[k] = 0;
            else if (c) m_pos[k] += (st == 1) ? 1 : -1;
            if (st == 2)   m_err[k] = 1'b1;
            else if (eclr) m_err[k] = 1'b0;
        end
        m_ab = ab;
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic clear_capture();
        for (int k = 0; k < 4; k++) begin
            pulses[k] = 0; first_edge[k] = -1; exp_cnt[k] = 0;
        end
    endtask

    task automatic capture(input int e);
        for (int k = 0; k < 4; k++) begin
            if (pulse_v[k] === 1'b1) begin
                pulses[k]++;
                if (first_edge[k] < 0) first_edge[k] = e;
            end
        end
    endtask

    // Change the channels at a falling edge, hold for dwell clocks; optional
    // clears are asserted across the clock on which the event is decoded.
    task automatic do_step(input logic [1:0] ab, input int dwell, input bit pclr, input bit eclr);
        clear_capture();
        model_apply(ab, pclr, eclr);
        @(negedge clk);
        enc_a = ab[1];
        enc_b = ab[0];
        for (int e = 1; e <= dwell; e++) begin
            @(posedge clk);
            #1;
            capture(e);
            if (e == LAT - 1) begin pos_clr = pclr; err_clr = eclr; end
            if (e == LAT)     begin pos_clr = 1'b0; err_clr = 1'b0; end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        enc_a = 1'b0; enc_b = 1'b0; rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0; enc_a = 1'b0; enc_b = 1'b0; pos_clr = 1'b0; err_clr = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (act_pos(k) !== 0 || ticks_v[k] !== 1'b0 || pulse_v[k] !== 1'b0 || dir_v[k] !== 1'b0 || err_v[k] !== 1'b0) begin
                errors++;
                $display("FAIL reset[%0d]: got pos=%0h ticks=%b pulse=%b dir=%b err=%b, expected all 0",
                         k, act_pos(k), ticks_v[k], pulse_v[k], dir_v[k], err_v[k]);
            end
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_fwd_sweep();
        int total [4];
        logic [1:0] seq [4];
        seq = '{2'b10, 2'b11, 2'b01, 2'b00};
        for (int k = 0; k < 4; k++) total[k] = 0;
        for (int s = 0; s < 4; s++) begin
            do_step(seq[s], 200, 1'b0, 1'b0);
            for (int k = 0; k < 4; k++) begin
                total[k] += pulses[k];
                checks++;
                if (pulses[k] !== exp_cnt[k]) begin
                    errors++;
                    $display("FAIL fwd_pulses[%0d] step %0d: got %0d expected %0d", k, s, pulses[k], exp_cnt[k]);
                end
            end
        end
        checks++;
        if (total[0] !== 4 || pos_m4 !== 16'd4 || dir_v[0] !== 1'b1 || ticks_v[0] !== 1'b0) begin
            errors++;
            $display("FAIL fwd_sweep_m4: got pulses=%0d pos=%0h dir=%b ticks=%b expected 4/0004/1/0",
                     total[0], pos_m4, dir_v[0], ticks_v[0]);
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (act_pos(k) !== exp_pos(k) || ticks_v[k] !== m_ticks[k] || dir_v[k] !== m_dir[k] || err_v[k] !== m_err[k]) begin
                errors++;
                $display("FAIL fwd_state[%0d]: got pos=%0h ticks=%b dir=%b err=%b expected %0h/%b/%b/%b",
                         k, act_pos(k), ticks_v[k], dir_v[k], err_v[k], exp_pos(k), m_ticks[k], m_dir[k], m_err[k]);
            end
        end
    endtask

    task automatic test_reverse_latency();
        logic [1:0] seq [4];
        seq = '{2'b01, 2'b11, 2'b10, 2'b00};
        do_reset();
        for (int s = 0; s < 4; s++) begin
            do_step(seq[s], 10, 1'b0, 1'b0);
            checks++;
            if (pulses[0] !== 1 || first_edge[0] !== LAT) begin
                errors++;
                $display("FAIL rev_latency step %0d: got %0d pulses first at edge %0d, expected 1 at edge %0d",
                         s, pulses[0], first_edge[0], LAT);
            end
        end
        checks++;
        if (pos_m4 !== 16'hFFFC || dir_v[0] !== 1'b0) begin
            errors++;
            $display("FAIL rev_pos: got pos=%0h dir=%b expected fffc/0", pos_m4, dir_v[0]);
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (act_pos(k) !== exp_pos(k) || ticks_v[k] !== m_ticks[k] || dir_v[k] !== m_dir[k]) begin
                errors++;
                $display("FAIL rev_state[%0d]: got pos=%0h ticks=%b dir=%b expected %0h/%b/%b",
                         k, act_pos(k), ticks_v[k], dir_v[k], exp_pos(k), m_ticks[k], m_dir[k]);
            end
        end
    endtask

    // A held high for `width` clocks then released; watch 20 clocks.
    task automatic glitch(input int width);
        clear_capture();
        @(negedge clk);
        enc_a = 1'b1;
        for (int e = 1; e <= 20; e++) begin
            @(posedge clk);
            #1;
            capture(e);
            if (e == width) begin
                @(negedge clk);
                enc_a = 1'b0;
            end
        end
    endtask

    task automatic test_glitch();
        do_reset();
        glitch(FL - 1);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (pulses[k] !== 0 || act_pos(k) !== 0) begin
                errors++;
                $display("FAIL glitch_short[%0d]: got %0d pulses pos=%0h expected 0 pulses pos 0", k, pulses[k], act_pos(k));
            end
        end
        glitch(FL);
        model_apply(2'b10, 1'b0, 1'b0);
        model_apply(2'b00, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (pulses[k] !== exp_cnt[k] || act_pos(k) !== exp_pos(k) || ticks_v[k] !== m_ticks[k]) begin
                errors++;
                $display("FAIL glitch_accept[%0d]: got %0d pulses pos=%0h ticks=%b expected %0d/%0h/%b",
                         k, pulses[k], act_pos(k), ticks_v[k], exp_cnt[k], exp_pos(k), m_ticks[k]);
            end
        end
        checks++;
        if (first_edge[0] !== LAT) begin
            errors++;
            $display("FAIL glitch_latency: got first pulse at edge %0d expected %0d", first_edge[0], LAT);
        end
    endtask

    task automatic test_illegal();
        bit want [3];
        do_reset();
        want = '{1'b1, 1'b0, 1'b1};
        do_step(2'b11, 10, 1'b0, 1'b0);
        do_step(2'b11, 10, 1'b0, 1'b1);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (err_v[k] !== 1'b0 || act_pos(k) !== 0) begin
                errors++;
                $display("FAIL err_clr[%0d]: got err=%b pos=%0h expected 0/0", k, err_v[k], act_pos(k));
            end
        end
        do_step(2'b00, 10, 1'b0, 1'b1);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (err_v[k] !== 1'b1 || pulses[k] !== 0 || act_pos(k) !== exp_pos(k) || dir_v[k] !== m_dir[k]) begin
                errors++;
                $display("FAIL err_vs_clr[%0d]: got err=%b pulses=%0d pos=%0h expected err 1, no pulse, pos %0h",
                         k, err_v[k], pulses[k], act_pos(k), exp_pos(k));
            end
        end
        checks++;
        if (m_err[0] !== want[2]) begin
            errors++;
            $display("FAIL err_model: got %b expected %b", m_err[0], want[2]);
        end
    endtask

    task automatic test_modes();
        int total [4];
        do_reset();
        for (int k = 0; k < 4; k++) total[k] = 0;
        for (int s = 1; s <= 12; s++) begin
            do_step(from_idx(s), 8, 1'b0, 1'b0);
            for (int k = 0; k < 4; k++) total[k] += pulses[k];
        end
        checks++;
        if (pos_m1 !== 16'd3 || total[2] !== 3 || pos_m2 !== 16'd6 || total[1] !== 6 || pos_m4 !== 16'd12) begin
            errors++;
            $display("FAIL modes: got m1 pos=%0d pulses=%0d m2 pos=%0d pulses=%0d m4 pos=%0d expected 3/3/6/6/12",
                     pos_m1, total[2], pos_m2, total[1], pos_m4);
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (act_pos(k) !== exp_pos(k) || ticks_v[k] !== m_ticks[k] || dir_v[k] !== m_dir[k]) begin
                errors++;
                $display("FAIL modes_state[%0d]: got pos=%0h ticks=%b dir=%b expected %0h/%b/%b",
                         k, act_pos(k), ticks_v[k], dir_v[k], exp_pos(k), m_ticks[k], m_dir[k]);
            end
        end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int s = 1; s <= 7; s++) do_step(from_idx(s), 8, 1'b0, 1'b0);
        checks++;
        if (pos_w4 !== 4'h7) begin
            errors++;
            $display("FAIL wrap_pre: got %0h expected 7", pos_w4);
        end
        do_step(from_idx(8), 8, 1'b0, 1'b0);
        checks++;
        if (pos_w4 !== 4'h8 || pos_m4 !== 16'd8) begin
            errors++;
            $display("FAIL wrap_fwd: got w4=%0h m4=%0h expected 8/0008", pos_w4, pos_m4);
        end
        do_step(from_idx(7), 8, 1'b0, 1'b0);
        checks++;
        if (pos_w4 !== 4'h7 || dir_v[3] !== 1'b0) begin
            errors++;
            $display("FAIL wrap_rev: got %0h dir=%b expected 7/0", pos_w4, dir_v[3]);
        end
    endtask

    task automatic test_pos_clr();
        do_reset();
        do_step(2'b10, 8, 1'b0, 1'b0);
        do_step(2'b11, 8, 1'b0, 1'b0);
        do_step(2'b01, 10, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (act_pos(k) !== 0 || pulses[k] !== exp_cnt[k] || ticks_v[k] !== m_ticks[k] || dir_v[k] !== m_dir[k]) begin
                errors++;
                $display("FAIL pos_clr[%0d]: got pos=%0h pulses=%0d ticks=%b dir=%b expected 0/%0d/%b/%b",
                         k, act_pos(k), pulses[k], ticks_v[k], dir_v[k], exp_cnt[k], m_ticks[k], m_dir[k]);
            end
        end
        checks++;
        if (pulses[0] !== 1) begin
            errors++;
            $display("FAIL pos_clr_pulse: got %0d pulses expected 1", pulses[0]);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 40; n++) begin
            logic [1:0] ab;
            ab = 2'($urandom_range(0, 3));
            do_step(ab, $urandom_range(8, 12), ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0));
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (pulses[k] !== exp_cnt[k] || (exp_cnt[k] > 0 && first_edge[k] !== LAT)) begin
                    errors++;
                    $display("FAIL rand_pulse[%0d] n=%0d: got %0d pulses at edge %0d expected %0d at edge %0d",
                             k, n, pulses[k], first_edge[k], exp_cnt[k], LAT);
                end
                checks++;
                if (act_pos(k) !== exp_pos(k) || ticks_v[k] !== m_ticks[k] || dir_v[k] !== m_dir[k] || err_v[k] !== m_err[k]) begin
                    errors++;
                    $display("FAIL rand_state[%0d] n=%0d: got pos=%0h ticks=%b dir=%b err=%b expected %0h/%b/%b/%b",
                             k, n, act_pos(k), ticks_v[k], dir_v[k], err_v[k], exp_pos(k), m_ticks[k], m_dir[k], m_err[k]);
                end
            end
        end
    endtask

    task automatic test_reset_midop();
        do_reset();
        do_step(2'b10, 8, 1'b0, 1'b0);
        do_step(2'b11, 8, 1'b0, 1'b0);
        @(negedge clk);
        enc_a = 1'b1; enc_b = 1'b1;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (act_pos(k) !== 0 || ticks_v[k] !== 1'b0 || pulse_v[k] !== 1'b0 || dir_v[k] !== 1'b0 || err_v[k] !== 1'b0) begin
                errors++;
                $display("FAIL midop_reset[%0d]: got pos=%0h ticks=%b pulse=%b dir=%b err=%b expected all 0",
                         k, act_pos(k), ticks_v[k], pulse_v[k], dir_v[k], err_v[k]);
            end
        end
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        clear_capture();
        model_apply(2'b11, 1'b0, 1'b0);
        for (int e = 1; e <= 14; e++) begin
            @(posedge clk);
            #1;
            capture(e);
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (err_v[k] !== m_err[k] || pulses[k] !== 0 || act_pos(k) !== 0) begin
                errors++;
                $display("FAIL resting_11[%0d]: got err=%b pulses=%0d pos=%0h expected %b/0/0",
                         k, err_v[k], pulses[k], act_pos(k), m_err[k]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_fwd_sweep();
        test_reverse_latency();
        test_glitch();
        test_illegal();
        test_modes();
        test_wrap();
        test_pos_clr();
        test_random();
        test_reset_midop();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
